// File: rtl/reset_seq_monitor.sv
// reset_seq_monitor
// Receiving end of the staged reset-release sequencer. Watches the five
// per-stage release lines and tracks which release phase the controller is in.
// It flags releases that arrive out of order and phases that were held too
// briefly, and it reports how long each phase was held (dwell).
//
// Release vector V = {rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp}. A 0 on a
// line means that stage has been released. Phase Pn has the n most significant
// lines released, so the pattern for Pn is 5'b11111 >> n.
//
// The stage lines are sampled directly, with no synchronizer. The controller
// drives them on this same clock. All outputs come from registers, so each
// output follows its input edge by one cycle.
module reset_seq_monitor #(
    parameter int unsigned MIN_DWELL = 100_000_000,
    parameter int          CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_mem,
    input  logic             rst_pe,
    input  logic             rst_3b3,
    input  logic             rst_2b2,
    input  logic             rst_disp,
    output logic [2:0]       phase,
    output logic             phase_valid,
    output logic             seq_done,
    output logic [CNT_W-1:0] dwell_cnt,
    output logic [CNT_W-1:0] last_dwell,
    output logic             last_dwell_vld,
    output logic             err_order,
    output logic             err_dwell
);

    // The state encoding doubles as the phase output: P0..P5 map to 0..5, and
    // ERR maps to 3'b111.
    typedef enum logic [2:0] {
        ST_P0  = 3'd0,
        ST_P1  = 3'd1,
        ST_P2  = 3'd2,
        ST_P3  = 3'd3,
        ST_P4  = 3'd4,
        ST_P5  = 3'd5,
        ST_ERR = 3'b111
    } state_t;

    localparam logic [4:0]       PAT_P0  = 5'b11111;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // The dwell threshold is compared at a width that holds both the counter
    // and the 32-bit parameter. A small CNT_W therefore cannot truncate
    // MIN_DWELL.
    localparam int               CMP_W   = (CNT_W > 32) ? CNT_W : 32;
    localparam logic [CMP_W-1:0] MIN_EXT = CMP_W'(MIN_DWELL);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0] last_q, last_d;
    logic             vld_q, vld_d;
    logic             eo_q, eo_d;
    logic             ed_q, ed_d;

    logic [4:0]       v;
    logic [2:0]       st_idx;
    logic [2:0]       nxt_idx;
    logic [4:0]       pat_cur;
    logic [4:0]       pat_nxt;
    logic [CMP_W-1:0] dwell_ext;

    assign v         = {rst_mem, rst_pe, rst_3b3, rst_2b2, rst_disp};
    assign st_idx    = state_q;
    assign nxt_idx   = st_idx + 3'd1;
    // In P5 the value of pat_nxt is never used. Advancing is blocked there.
    assign pat_cur   = PAT_P0 >> st_idx;
    assign pat_nxt   = PAT_P0 >> nxt_idx;
    assign dwell_ext = CMP_W'(dwell_q);

    // State register and tracked counters. rst clears them immediately and
    // does not wait for a clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_P0;
            dwell_q <= '0;
            last_q  <= '0;
            vld_q   <= 1'b0;
            eo_q    <= 1'b0;
            ed_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            eo_q    <= eo_d;
            ed_q    <= ed_d;
        end
    end

    // Next-state logic. The checks run in priority order: hold the current
    // pattern, advance one phase, controller restart, and otherwise error.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        last_d  = last_q;
        vld_d   = 1'b0;
        eo_d    = eo_q;
        ed_d    = ed_q;
        if (state_q == ST_ERR) begin
            // Only a full restart pattern leaves ERR. The counter stays at 0
            // until then.
            if (v == PAT_P0) begin
                state_d = ST_P0;
                dwell_d = CNT_ONE;
            end else begin
                dwell_d = '0;
            end
        end else if (v == pat_cur) begin
            if (dwell_q != CNT_MAX) begin
                dwell_d = dwell_q + CNT_ONE;
            end
        end else if (state_q != ST_P5 && v == pat_nxt) begin
            // A legal advance still happens when the dwell was too short. The
            // short dwell is only flagged.
            state_d = state_t'(nxt_idx);
            last_d  = dwell_q;
            vld_d   = 1'b1;
            dwell_d = CNT_ONE;
            if (dwell_ext < MIN_EXT) begin
                ed_d = 1'b1;
            end
        end else if (v == PAT_P0) begin
            state_d = ST_P0;
            dwell_d = CNT_ONE;
        end else begin
            state_d = ST_ERR;
            eo_d    = 1'b1;
            dwell_d = '0;
        end
    end

    assign phase          = state_q;
    assign phase_valid    = (state_q != ST_ERR);
    assign seq_done       = (state_q == ST_P5);
    assign dwell_cnt      = dwell_q;
    assign last_dwell     = last_q;
    assign last_dwell_vld = vld_q;
    assign err_order      = eo_q;
    assign err_dwell      = ed_q;

endmodule
